// File: rtl/cpu_sys_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_sys_pkg
// Description : Shared types and constants for the VeriRISC loader and its
//               phase generator: loader state encoding, phase decode points,
//               default image size and watchdog limit.
// Revision    : 1.0  initial release
// ============================================================================
package cpu_sys_pkg;

  // Loader / run-supervisor states, fixed 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_HOLD   = 3'd2,
    ST_RUN    = 3'd3,
    ST_HALTED = 3'd4
  } loader_state_t;

  // Phase counter value at which the ALU strobe is active (low)
  localparam logic [3:0] PHASE_ALU  = 4'hC;
  // Final phase of an instruction cycle; halt is sampled here
  localparam logic [3:0] PHASE_LAST = 4'hF;

  // Default number of words in a program image
  localparam int DEF_MEM_DEPTH     = 32;
  // Default watchdog limit in instruction cycles
  localparam int DEF_TIMEOUT_INSTR = 255;

  // Increment an 8-bit counter, holding at 255 instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : cpu_loader_if
// Description : Byte-stream input and memory write port of the program
//               loader. The master modport is the loader side; the slave
//               modport is the stream source / memory side.
// Revision    : 1.0  initial release
// ============================================================================
interface cpu_loader_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
);

  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;

  modport master (
    input  in_valid,
    input  in_data,
    output in_ready,
    output mem_wr,
    output mem_addr,
    output mem_data
  );

  modport slave (
    output in_valid,
    output in_data,
    input  in_ready,
    input  mem_wr,
    input  mem_addr,
    input  mem_data
  );

endinterface
`default_nettype wire

// File: rtl/phase_gen.sv
`default_nettype none
// ============================================================================
// Module      : phase_gen
// Description : 4-bit CPU phase counter with enable and synchronous clear.
//               Decodes the four CPU phase strobes and a pulse marking the
//               last phase of each 16-clock instruction cycle.
// Revision    : 1.0  initial release
// ============================================================================
module phase_gen
  import cpu_sys_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic control_clk,
  output logic cpu_clk,
  output logic fetch,
  output logic alu_clk,
  output logic last_phase
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Next count: clear has priority, otherwise count up and wrap 15 -> 0
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 4'd0;
    end else if (en) begin
      count_d = count_q + 4'd1;
    end
  end

  // Phase counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  // Strobes are pure decodes of the registered count, so they are glitch-free
  // relative to clk and take their idle values whenever the count is 0.
  assign control_clk = ~count_q[0];
  assign cpu_clk     = count_q[1];
  assign fetch       = ~count_q[3];
  assign alu_clk     = (count_q != PHASE_ALU);
  assign last_phase  = (count_q == PHASE_LAST);

endmodule
`default_nettype wire

// File: rtl/cpu_loader.sv
`default_nettype none
// ============================================================================
// Module      : cpu_loader
// Description : Program loader and run supervisor for the VeriRISC CPU.
//               Streams a program image into CPU memory, holds the CPU in
//               reset for a fixed interval, drives the CPU phase strobes and
//               reports completion on halt or on a watchdog timeout.
// Revision    : 1.0  initial release
// ============================================================================
module cpu_loader
  import cpu_sys_pkg::*;
#(
  parameter int ADDR_WIDTH    = 5,
  parameter int DATA_WIDTH    = 8,
  parameter int MEM_DEPTH     = DEF_MEM_DEPTH,
  parameter int RST_CYCLES    = 2,
  parameter int TIMEOUT_INSTR = DEF_TIMEOUT_INSTR
) (
  input  logic         clk,
  input  logic         rst,          // asynchronous, active low
  input  logic         start,
  cpu_loader_if.master bus,
  output logic         cpu_rst,      // active low
  input  logic         cpu_halt,
  output logic         control_clk,
  output logic         cpu_clk,
  output logic         fetch,
  output logic         alu_clk,
  output logic [7:0]   instr_count,
  output logic         done,
  output logic         timeout
);

  // A 1-cycle hold still needs a 1-bit counter
  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [HOLD_W-1:0]     HOLD_LAST   = HOLD_W'(RST_CYCLES - 1);
  localparam logic [7:0]            TIMEOUT_CNT = 8'(TIMEOUT_INSTR);

  loader_state_t         state_q,       state_d;
  logic [ADDR_WIDTH-1:0] load_addr_q,   load_addr_d;
  logic [HOLD_W-1:0]     hold_cnt_q,    hold_cnt_d;
  logic                  mem_wr_q,      mem_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q,    mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q,    mem_data_d;
  logic                  cpu_rst_q,     cpu_rst_d;
  logic [7:0]            instr_count_q, instr_count_d;
  logic                  done_q,        done_d;
  logic                  timeout_q,     timeout_d;

  logic                  w_in_ready;
  logic                  w_handshake;
  logic                  w_last_phase;
  logic                  w_phase_en;
  logic                  w_phase_clr;
  logic [7:0]            w_instr_inc;

  // in_ready is a decode of state alone, so it never depends on in_valid
  assign w_in_ready  = (state_q == ST_LOAD);
  assign w_handshake = bus.in_valid && w_in_ready;

  // The phase counter only runs in RUN; every other state pins it to 0 so
  // the strobes sit at their idle values and RUN always starts at phase 0.
  assign w_phase_en  = (state_q == ST_RUN);
  assign w_phase_clr = (state_q != ST_RUN);

  assign w_instr_inc = sat_inc8(instr_count_q);

  phase_gen u_phase_gen (
    .clk         (clk),
    .rst_n       (rst),
    .en          (w_phase_en),
    .clr         (w_phase_clr),
    .control_clk (control_clk),
    .cpu_clk     (cpu_clk),
    .fetch       (fetch),
    .alu_clk     (alu_clk),
    .last_phase  (w_last_phase)
  );

  // Next-state and next-output computation for the loader / supervisor
  always_comb begin
    state_d       = state_q;
    load_addr_d   = load_addr_q;
    hold_cnt_d    = hold_cnt_q;
    mem_wr_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    instr_count_d = instr_count_q;
    done_d        = done_q;
    timeout_d     = timeout_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LOAD;
          load_addr_d = '0;
          done_d      = 1'b0;
          timeout_d   = 1'b0;
        end
      end

      ST_LOAD: begin
        // Every accepted byte becomes exactly one registered write; a
        // stalled stream simply leaves the loader waiting here.
        if (w_handshake) begin
          mem_wr_d    = 1'b1;
          mem_addr_d  = load_addr_q;
          mem_data_d  = bus.in_data;
          load_addr_d = load_addr_q + ADDR_WIDTH'(1);
          if (load_addr_q == LAST_ADDR) begin
            state_d    = ST_HOLD;
            hold_cnt_d = '0;
          end
        end
      end

      ST_HOLD: begin
        instr_count_d = 8'd0;
        done_d        = 1'b0;
        timeout_d     = 1'b0;
        if (hold_cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      ST_RUN: begin
        // Halt is only meaningful at the end of an instruction cycle, and
        // it takes priority over the watchdog on that same cycle.
        if (w_last_phase) begin
          instr_count_d = w_instr_inc;
          if (cpu_halt) begin
            state_d   = ST_HALTED;
            done_d    = 1'b1;
            timeout_d = 1'b0;
          end else if (w_instr_inc == TIMEOUT_CNT) begin
            state_d   = ST_HALTED;
            done_d    = 1'b1;
            timeout_d = 1'b1;
          end
        end
      end

      ST_HALTED: begin
        // A new start overrides whatever cpu_halt is doing
        if (start) begin
          state_d     = ST_LOAD;
          load_addr_d = '0;
          done_d      = 1'b0;
          timeout_d   = 1'b0;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The CPU is released in RUN and stays released in HALTED so its state
    // can be inspected; it goes back into reset on the edge that leaves.
    cpu_rst_d = (state_d == ST_RUN) || (state_d == ST_HALTED);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      load_addr_q   <= '0;
      hold_cnt_q    <= '0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      cpu_rst_q     <= 1'b0;
      instr_count_q <= 8'd0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_addr_q   <= load_addr_d;
      hold_cnt_q    <= hold_cnt_d;
      mem_wr_q      <= mem_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_q    <= mem_data_d;
      cpu_rst_q     <= cpu_rst_d;
      instr_count_q <= instr_count_d;
      done_q        <= done_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.mem_wr   = mem_wr_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign cpu_rst      = cpu_rst_q;
  assign instr_count  = instr_count_q;
  assign done         = done_q;
  assign timeout      = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_loader
// Description : Self-checking bench for cpu_loader. Streams images with
//               gaps, checks every write, the reset hold, the phase strobes
//               cycle by cycle, halt / timeout completion, restart priority
//               and asynchronous reset in LOAD and RUN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_loader;

  localparam int AW    = 5;
  localparam int DW    = 8;
  localparam int DEPTH = 32;
  localparam int RSTC  = 2;
  localparam int TMO   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       cpu_halt;
  logic       cpu_rst;
  logic       control_clk;
  logic       cpu_clk;
  logic       fetch;
  logic       alu_clk;
  logic [7:0] instr_count;
  logic       done;
  logic       timeout;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] img [DEPTH];

  cpu_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  cpu_loader #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .MEM_DEPTH     (DEPTH),
    .RST_CYCLES    (RSTC),
    .TIMEOUT_INSTR (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bus         (bus),
    .cpu_rst     (cpu_rst),
    .cpu_halt    (cpu_halt),
    .control_clk (control_clk),
    .cpu_clk     (cpu_clk),
    .fetch       (fetch),
    .alu_clk     (alu_clk),
    .instr_count (instr_count),
    .done        (done),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe values for a phase, straight from the phase decode rules
  task automatic chk_phase(input string tag, input int ph);
    chk({tag, "_control"}, control_clk, (ph % 2) == 0);
    chk({tag, "_cpuclk"},  cpu_clk,     (ph % 4) >= 2);
    chk({tag, "_fetch"},   fetch,       ph < 8);
    chk({tag, "_alu"},     alu_clk,     ph != 12);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},   bus.in_ready, 0);
    chk({tag, "_wr"},      bus.mem_wr,   0);
    chk({tag, "_addr"},    bus.mem_addr, 0);
    chk({tag, "_data"},    bus.mem_data, 0);
    chk({tag, "_cpurst"},  cpu_rst,      0);
    chk({tag, "_icount"},  instr_count,  0);
    chk({tag, "_done"},    done,         0);
    chk({tag, "_timeout"}, timeout,      0);
    chk_phase(tag, 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++) img[i] = DW'($urandom);
  endtask

  // Start from IDLE or HALTED; optionally raise cpu_halt in the same cycle
  task automatic do_start(input string tag, input bit with_halt);
    start    = 1'b1;
    cpu_halt = with_halt;
    tick();
    start    = 1'b0;
    cpu_halt = 1'b0;
    chk({tag, "_ready"},   bus.in_ready, 1);
    chk({tag, "_cpurst"},  cpu_rst,      0);
    chk({tag, "_done"},    done,         0);
    chk({tag, "_timeout"}, timeout,      0);
  endtask

  // Stream img[] into the loader. gap_mode 0: idle every third cycle,
  // 1: random idles, 2: back-to-back. abort_at >= 0 pulls reset once that
  // many bytes have been accepted.
  task automatic load_image(input int gap_mode, input int abort_at);
    int sent;
    int wr;
    int cyc;
    bit hs;
    bit hs_prev;
    bit gap;
    sent    = 0;
    wr      = 0;
    cyc     = 0;
    hs_prev = 1'b0;
    while (wr < DEPTH && cyc < 400) begin
      if (abort_at >= 0 && sent == abort_at) begin
        bus.in_valid = 1'b0;
        start        = 1'b0;
        #2 rst = 1'b0;
        #1 chk_reset_vals("load_abort");
        return;
      end
      chk("load_wr", bus.mem_wr, hs_prev);
      if (hs_prev && bus.mem_wr === 1'b1) begin
        chk("load_addr", bus.mem_addr, wr);
        chk("load_data", bus.mem_data, img[wr]);
      end
      if (hs_prev) wr++;
      if (wr == DEPTH) break;
      chk("load_ready", bus.in_ready, sent < DEPTH);
      case (gap_mode)
        0:       gap = (cyc % 3) == 2;
        1:       gap = $urandom_range(0, 2) == 0;
        default: gap = 1'b0;
      endcase
      hs           = (sent < DEPTH) && !gap;
      bus.in_valid = hs;
      bus.in_data  = hs ? img[sent] : DW'($urandom);
      start        = $urandom_range(0, 7) == 0;  // must be ignored in LOAD
      tick();
      if (hs) sent++;
      hs_prev = hs;
      cyc++;
    end
    bus.in_valid = 1'b0;
    start        = 1'b0;
    chk("load_count", wr, DEPTH);
    chk("load_ready_end", bus.in_ready, 0);
  endtask

  // CPU held in reset for RSTC cycles after the last write, then released
  task automatic hold_check();
    for (int i = 0; i < RSTC; i++) begin
      chk("hold_cpurst", cpu_rst, 0);
      chk("hold_ready", bus.in_ready, 0);
      start = $urandom_range(0, 1);  // must be ignored in HOLD
      tick();
      start = 1'b0;
    end
    chk("hold_release", cpu_rst, 1);
    chk("hold_wr", bus.mem_wr, 0);
  endtask

  // Run the CPU. halt_instr (1-based, 0 = never) / halt_phase place a halt
  // pulse; noise adds random halts on phases other than 15; abort_instr /
  // abort_phase pull reset mid-run.
  task automatic run_program(input int halt_instr, input int halt_phase, input bit noise,
                             input int abort_instr, input int abort_phase);
    int t;
    int ph;
    int ic;
    bit fin;
    bit exp_to;
    t      = 0;
    fin    = 1'b0;
    exp_to = 1'b0;
    ic     = 0;
    while (!fin && t < 16 * 300) begin
      ph = t % 16;
      ic = t / 16;
      if (abort_instr > 0 && ic + 1 == abort_instr && ph == abort_phase) begin
        #2 rst = 1'b0;
        #1 chk_reset_vals("run_abort");
        return;
      end
      chk_phase("run", ph);
      chk("run_icount", instr_count, ic);
      chk("run_done", done, 0);
      chk("run_cpurst", cpu_rst, 1);
      cpu_halt = (ic + 1 == halt_instr && ph == halt_phase) ||
                 (noise && ph != 15 && $urandom_range(0, 1) == 1);
      start    = $urandom_range(0, 15) == 0;  // must be ignored in RUN
      if (ph == 15) begin
        if (cpu_halt) begin
          fin    = 1'b1;
          exp_to = 1'b0;
        end else if (ic + 1 == TMO) begin
          fin    = 1'b1;
          exp_to = 1'b1;
        end
      end
      tick();
      cpu_halt = 1'b0;
      start    = 1'b0;
      t++;
    end
    chk("run_finished", fin, 1);
    chk("end_done", done, 1);
    chk("end_timeout", timeout, exp_to);
    chk("end_icount", instr_count, ic + 1);
    chk("end_cpurst", cpu_rst, 1);
    chk("end_ready", bus.in_ready, 0);
    chk_phase("end", 0);
  endtask

  // HALTED holds its results whatever cpu_halt does
  task automatic halted_hold(input int n, input int exp_ic, input bit exp_to);
    for (int i = 0; i < n; i++) begin
      cpu_halt = $urandom_range(0, 1);
      tick();
      chk("halted_done", done, 1);
      chk("halted_timeout", timeout, exp_to);
      chk("halted_icount", instr_count, exp_ic);
      chk("halted_cpurst", cpu_rst, 1);
      chk_phase("halted", 0);
    end
    cpu_halt = 1'b0;
  endtask

  initial begin
    rst          = 1'b0;
    start        = 1'b0;
    cpu_halt     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #3 chk_reset_vals("por");
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;

    // IDLE ignores the stream
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'($urandom);
      tick();
      chk("idle_ready", bus.in_ready, 0);
      chk("idle_wr", bus.mem_wr, 0);
      chk("idle_cpurst", cpu_rst, 0);
    end
    bus.in_valid = 1'b0;

    // Ramp image with a gap every third cycle, halt at end of 3rd instruction
    for (int i = 0; i < DEPTH; i++) img[i] = DW'(i);
    do_start("start1", 1'b0);
    load_image(0, -1);
    hold_check();
    run_program(3, 15, 1'b0, 0, 0);
    halted_hold(5, 3, 1'b0);

    // start + cpu_halt together restart; halt at the wrong phase then timeout
    fill_random();
    do_start("restart", 1'b1);
    load_image(1, -1);
    hold_check();
    run_program(1, 7, 1'b1, 0, 0);
    halted_hold(4, TMO, 1'b1);

    // Reset while loading address 17
    fill_random();
    do_start("start3", 1'b0);
    load_image(1, 17);
    @(posedge clk);
    #2 rst = 1'b1;
    tick();
    chk_reset_vals("post_load_rst");

    // Full reload from address 0, then reset mid-run at count 9
    fill_random();
    do_start("start4", 1'b0);
    load_image(2, -1);
    hold_check();
    run_program(0, 0, 1'b1, 2, 9);
    @(posedge clk);
    #2 rst = 1'b1;
    tick();
    chk_reset_vals("post_run_rst");

    // Recovery run ending in a halt on the 2nd instruction
    fill_random();
    do_start("start5", 1'b0);
    load_image(1, -1);
    hold_check();
    run_program(2, 15, 1'b1, 0, 0);
    halted_hold(2, 2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_loader.md
# cpu_loader

Program loader and run supervisor for the VeriRISC CPU. It accepts a 32-byte program image over a valid/ready byte stream and writes it into CPU memory through a write port. It then holds the CPU in reset for a fixed interval and generates the CPU phase strobes while the program runs. It reports completion when the CPU asserts halt, or reports a timeout after a bounded number of instruction cycles.

## Interface
- `ADDR_WIDTH`, default 5: memory address width.
- `DATA_WIDTH`, default 8: memory word / stream byte width.
- `MEM_DEPTH`, default 32: number of words loaded per image.
- `RST_CYCLES`, default 2: clk cycles cpu_rst is held low after load.
- `TIMEOUT_INSTR`, default 255: instruction cycles allowed before timeout (must be 1..255).
- `clk`  in  1: single system clock; all logic on posedge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: single-cycle request to load and run a new image.
- `in_valid`  in  1: stream byte valid.
- `in_data`  in  DATA_WIDTH: stream byte.
- `in_ready`  out  1: loader accepts a byte this cycle.
- `mem_wr`  out  1: memory write strobe.
- `mem_addr`  out  ADDR_WIDTH: write address.
- `mem_data`  out  DATA_WIDTH: write data.
- `cpu_rst`  out  1: active-low reset to the CPU.
- `cpu_halt`  in  1: CPU halt flag.
- `control_clk`, `cpu_clk`, `fetch`, `alu_clk`  out  1 each: CPU phase strobes.
- `instr_count`  out  8: completed instruction cycles since release from reset.
- `done`  out  1: run finished (halt or timeout); sticky until the next start.
- `timeout`  out  1: run ended by the watchdog; sticky until the next start.

## Operation
- States: IDLE, LOAD, HOLD, RUN, HALTED.
- IDLE:
  - in_ready=0, cpu_rst=0, phase counter held at 0.
  - start -> LOAD, with load address cleared to 0.
- LOAD:
  - in_ready=1.
  - Each handshake (in_valid && in_ready) registers mem_addr=load address, mem_data=in_data, and mem_wr=1 for exactly one cycle. The load address then increments.
  - The handshake at address MEM_DEPTH-1 moves to HOLD, and in_ready drops in the same cycle the state changes.
  - Gaps in in_valid stall the load without limit.
- HOLD:
  - cpu_rst=0 for RST_CYCLES clk cycles, then RUN.
  - instr_count, done and timeout are cleared.
- RUN:
  - cpu_rst=1.
  - The 4-bit phase counter increments every clk and wraps 15 -> 0.
  - Phase decode: control_clk=~count[0], cpu_clk=count[1], fetch=~count[3], alu_clk=~(count==12).
  - At count==15: instr_count increments (saturating at 255), and cpu_halt is sampled.
  - If cpu_halt=1 at count==15: -> HALTED with done=1, timeout=0.
  - Else, if the incremented instr_count equals TIMEOUT_INSTR: -> HALTED with done=1, timeout=1.
  - cpu_halt at any other count is ignored.
- HALTED:
  - Phase counter is forced to 0; cpu_rst stays 1, so CPU state remains observable.
  - done, timeout and instr_count are held.
  - start -> LOAD, clearing done and timeout, with cpu_rst=0 from that edge.
- start is ignored in LOAD, HOLD and RUN.
- Simultaneous events:
  - Halt and timeout on the same count==15: halt wins.
  - start and cpu_halt in HALTED: start wins.

## Timing
- Reset values of all outputs:
  - in_ready=0, mem_wr=0, mem_addr=0, mem_data=0, cpu_rst=0, instr_count=0, done=0, timeout=0.
  - Phase counter 0, giving control_clk=1, cpu_clk=0, fetch=1, alu_clk=1.
- Reset asserted mid-operation (any state) returns to IDLE immediately and asynchronously, with the above values. A partially loaded image is abandoned.
- Write latency: mem_wr is asserted one cycle after its handshake.
- Load duration: minimum MEM_DEPTH+1 cycles from the first handshake to the last mem_wr.
- HOLD lasts exactly RST_CYCLES cycles. The first RUN cycle sees count=0.
- One instruction cycle is 16 clk cycles. done rises on the edge following count==15.
- All outputs are registered or decoded directly from registered state; there are no combinational paths from inputs to outputs except in_ready, which depends on state only.

## Structure
- Shared package `cpu_sys_pkg`:
  - `loader_state_t` enum.
  - Phase decode constants: ALU phase 4'hC, last phase 4'hF.
  - Default MEM_DEPTH and TIMEOUT_INSTR.
- Existing `opcodes` package unchanged.
- One sub-module, `phase_gen`:
  - 4-bit counter with enable and synchronous clear.
  - Outputs the four phase strobes and a last_phase pulse.

## Test plan
- Load with gaps: 32 bytes 8'h00..8'h1F with in_valid deasserted every third cycle -> exactly 32 mem_wr pulses, addr 0..31, mem_data==addr, in_ready=0 after the 32nd byte, cpu_rst low 2 cycles then high.
- Phase decode in RUN over counts 0..15:
  - alu_clk=0 only at count 12.
  - fetch=1 for counts 0..7.
  - cpu_clk=1 for counts 2,3,6,7,10,11,14,15.
- Halt: cpu_halt=1 only at count 15 of the 3rd instruction -> done=1 next edge, timeout=0, instr_count=3, phase strobes at reset values.
- Halt at wrong phase: cpu_halt pulsed at count 7 only -> no state change. Timeout with TIMEOUT_INSTR=4 and halt never set -> done=1, timeout=1, instr_count=4.
- Restart priority: start and cpu_halt both high in HALTED -> LOAD, done=0, timeout=0, cpu_rst=0, in_ready=1 next cycle.
- Async reset at load address 17 and mid-RUN at count 9 -> all outputs at reset values before the next clk edge. The next start reloads from address 0.
